// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter: shares one single-port memory between an instruction-fetch port
// and a load/store port. Data port has priority, bounded by a starvation limit
// that forces a pending fetch through; stuck accesses are aborted by a timeout.
module mem_arbiter #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned STARVE_MAX  = 3,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [DATA_W-1:0] if_addr,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [3:0]        dm_be,
   input  logic [DATA_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_valid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              bus_err,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned SW = (STARVE_MAX < 1)  ? 1 : $clog2(STARVE_MAX + 1);
   localparam int unsigned TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY_IF = 2'd1,
      ST_BUSY_DM = 2'd2
   } state_e;

   // Memory command captured at grant time and held for the whole access.
   typedef struct packed {
      logic              we;
      logic [3:0]        be;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_cmd_t;

   state_e            state_q, state_d;
   mem_cmd_t          cmd_q, cmd_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

   logic busy;
   logic starve_ok;
   logic tmo_hit;
   logic done;
   logic grant_if;
   logic grant_dm;

   assign busy      = (state_q != ST_IDLE);
   assign starve_ok = (starve_q < SW'(STARVE_MAX));
   // Expires in the TIMEOUT_CYC-th BUSY cycle: tmo_q counts prior ack-less cycles.
   assign tmo_hit   = busy && (tmo_q == TW'(TIMEOUT_CYC - 1));
   assign done      = busy && (mem_ack || tmo_hit);
   assign grant_if  = (state_q == ST_IDLE) && (state_d == ST_BUSY_IF);
   assign grant_dm  = (state_q == ST_IDLE) && (state_d == ST_BUSY_DM);

   assign mem_req   = busy;
   assign mem_we    = cmd_q.we;
   assign mem_be    = cmd_q.be;
   assign mem_addr  = cmd_q.addr;
   assign mem_wdata = cmd_q.wdata;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state: data first unless the fetch has been starved, exit BUSY on ack/timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (dm_req && starve_ok) state_d = ST_BUSY_DM;
            else if (if_req)         state_d = ST_BUSY_IF;
            else if (dm_req)         state_d = ST_BUSY_DM;
         end
         ST_BUSY_IF, ST_BUSY_DM: begin
            if (done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs: same-cycle completion pulses; ack wins over a coincident timeout.
   always_comb begin
      if_valid = 1'b0;
      dm_valid = 1'b0;
      bus_err  = 1'b0;
      if_rdata = if_rdata_q;
      dm_rdata = dm_rdata_q;
      if (!reset) begin
         case (state_q)
            ST_BUSY_IF: begin
               if (mem_ack) begin
                  if_valid = 1'b1;
                  if_rdata = mem_rdata;
               end else if (tmo_hit) begin
                  if_valid = 1'b1;
                  bus_err  = 1'b1;
               end
            end
            ST_BUSY_DM: begin
               if (mem_ack) begin
                  dm_valid = 1'b1;
                  dm_rdata = mem_rdata;
               end else if (tmo_hit) begin
                  dm_valid = 1'b1;
                  bus_err  = 1'b1;
               end
            end
            default: ;
         endcase
      end
      stall_if  = if_req & ~if_valid;
      stall_mem = dm_req & ~dm_valid;
   end

   // Datapath next values: command latch, starvation and timeout counters, read data.
   always_comb begin
      cmd_d      = cmd_q;
      starve_d   = starve_q;
      tmo_d      = tmo_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;

      if (grant_dm) begin
         cmd_d.we    = dm_we;
         cmd_d.be    = dm_be;
         cmd_d.addr  = dm_addr;
         cmd_d.wdata = dm_wdata;
      end else if (grant_if) begin
         cmd_d.we    = 1'b0;
         cmd_d.be    = 4'hF;
         cmd_d.addr  = if_addr;
         cmd_d.wdata = '0;
      end

      if (state_q == ST_IDLE) begin
         tmo_d = '0;
         if (grant_if || !if_req) starve_d = '0;
         else if (grant_dm && starve_ok) starve_d = starve_q + SW'(1);
      end else if (!mem_ack) begin
         tmo_d = tmo_q + TW'(1);
      end

      if ((state_q == ST_BUSY_IF) && mem_ack) if_rdata_d = mem_rdata;
      if ((state_q == ST_BUSY_DM) && mem_ack) dm_rdata_d = mem_rdata;
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_q      <= '0;
         starve_q   <= '0;
         tmo_q      <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         cmd_q      <= cmd_d;
         starve_q   <= starve_d;
         tmo_q      <= tmo_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

endmodule
